// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester and memory bus bundle for mem_bus_arbiter
//
// Purpose: carries both requester ports, the shared response signals and the
// single memory port of the arbiter.
// Modports:
//   slave  - the arbiter: samples requests and mem_rdata, drives acks,
//            rdata, status and the memory strobes/address/write data.
//   master - the surrounding environment (requesters plus memory).
// Signals:
//   req0/we0/addr0/wdata0, ack0  port 0 (CPU core)
//   req1/we1/addr1/wdata1, ack1  port 1 (auxiliary master)
//   rdata, busy, gnt_id          shared response and status
//   mem_re/mem_we/mem_addr/mem_wdata/mem_rdata  memory side

interface mem_bus_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;

    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              gnt_id;

    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, ack1, rdata, busy, gnt_id,
        output mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, ack1, rdata, busy, gnt_id,
        input  mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port arbiter in front of a single memory port
//
// Purpose: grants one of two requesters (port 0 CPU, port 1 auxiliary),
// latches its request, issues one memory strobe, waits MEM_LAT cycles for
// read data and returns rdata with a one-cycle ack to the winner.
// Contention is resolved round-robin; with ARB_FIXED_PRIO_EN defined port 0
// always wins contention.
// Parameters: DATA_W data width, ADDR_W address width, MEM_LAT read latency
// (1..15 cycles from the strobe cycle to valid mem_rdata).
// Ports:
//   CLOCK    system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   bus      mem_bus_arbiter_if.slave (requests, acks, status, memory port)

module mem_bus_arbiter #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input logic               CLOCK,
    input logic               RESET_N,
    mem_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int CNT_W = 4;

    state_t            state_q,  state_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              gnt_id_q, gnt_id_d;
    logic              last_q,   last_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              ack0_q,   ack0_d;
    logic              ack1_q,   ack1_d;

    logic              win;
    logic              win_we;

    // Winner selection; only meaningful while at least one req is high.
    always_comb begin
        win = 1'b0;
        if (bus.req0 && bus.req1) begin
`ifdef ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~last_q;
`endif
        end else begin
            win = bus.req1;
        end
    end

    assign win_we = win ? bus.we1 : bus.we0;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_id_d = win;
                    we_d     = win_we;
                    addr_d   = win ? bus.addr1  : bus.addr0;
                    wdata_d  = win ? bus.wdata1 : bus.wdata0;
                    // Strobes are registered here so they are high for
                    // exactly the ISSUE cycle.
                    mem_re_d = ~win_we;
                    mem_we_d = win_we;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    // Ack registered on entry to RESP so it lasts that cycle only.
                    ack0_d  = ~gnt_id_q;
                    ack1_d  = gnt_id_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // In fixed-priority builds this pointer is bookkeeping only.
                last_d  = gnt_id_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            gnt_id_q <= 1'b0;
            last_q   <= 1'b1;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
            mem_re_q <= mem_re_d;
            mem_we_q <= mem_we_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.gnt_id    = gnt_id_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter

module tb_mem_bus_arbiter;

    typedef struct {
        logic       port;
        logic [7:0] rdata;
        int         cyc;
    } ack_exp_t;

    typedef struct {
        logic       is_we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         cyc;
    } stb_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    ack_exp_t ackq1[$];
    stb_exp_t stbq1[$];
    ack_exp_t ackq3[$];
    stb_exp_t stbq3[$];

    mem_bus_arbiter_if #(.DATA_W(8), .ADDR_W(8)) b1();
    mem_bus_arbiter_if #(.DATA_W(8), .ADDR_W(8)) b3();

    mem_bus_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(1)) u_dut1 (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (b1)
    );

    mem_bus_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(3)) u_dut3 (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (b3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory for the MEM_LAT=1 instance: preset contents plus a written overlay.
    logic [7:0] mem1 [256] = '{default: 8'h00};
    logic       wr1  [256] = '{default: 1'b0};

    function automatic logic [7:0] init_val(input logic [7:0] a);
        case (a)
            8'h10:   return 8'hA5;
            8'h30:   return 8'h77;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (b1.mem_we) begin
            mem1[b1.mem_addr] <= b1.mem_wdata;
            wr1[b1.mem_addr]  <= 1'b1;
        end
    end

    assign b1.mem_rdata = wr1[b1.mem_addr] ? mem1[b1.mem_addr] : init_val(b1.mem_addr);
    // Time-varying data: only the correct sampling cycle yields the expected value.
    assign b3.mem_rdata = 8'(cyc) ^ 8'h5A;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the MEM_LAT=1 instance.
    always @(negedge clk) begin : mon1
        ack_exp_t ea;
        stb_exp_t es;
        if (b1.mem_re || b1.mem_we) begin
            chk("d1_strobe_exclusive", 32'(b1.mem_re & b1.mem_we), 32'd0);
            chk("d1_strobe_expected", 32'(stbq1.size() != 0), 32'd1);
            if (stbq1.size() != 0) begin
                es = stbq1.pop_front();
                chk("d1_strobe_we", 32'(b1.mem_we), 32'(es.is_we));
                chk("d1_strobe_addr", 32'(b1.mem_addr), 32'(es.addr));
                if (es.is_we) chk("d1_strobe_wdata", 32'(b1.mem_wdata), 32'(es.wdata));
                chk("d1_strobe_cycle", 32'(cyc), 32'(es.cyc));
            end
        end
        if (b1.ack0 || b1.ack1) begin
            chk("d1_ack_exclusive", 32'(b1.ack0 & b1.ack1), 32'd0);
            chk("d1_ack_expected", 32'(ackq1.size() != 0), 32'd1);
            if (ackq1.size() != 0) begin
                ea = ackq1.pop_front();
                chk("d1_ack_port", 32'(b1.ack1), 32'(ea.port));
                chk("d1_gnt_id", 32'(b1.gnt_id), 32'(ea.port));
                chk("d1_ack_rdata", 32'(b1.rdata), 32'(ea.rdata));
                chk("d1_ack_cycle", 32'(cyc), 32'(ea.cyc));
            end
        end
    end

    // Monitor for the MEM_LAT=3 instance.
    always @(negedge clk) begin : mon3
        ack_exp_t ea;
        stb_exp_t es;
        if (b3.mem_re || b3.mem_we) begin
            chk("d3_strobe_expected", 32'(stbq3.size() != 0), 32'd1);
            if (stbq3.size() != 0) begin
                es = stbq3.pop_front();
                chk("d3_strobe_we", 32'(b3.mem_we), 32'(es.is_we));
                chk("d3_strobe_addr", 32'(b3.mem_addr), 32'(es.addr));
                chk("d3_strobe_cycle", 32'(cyc), 32'(es.cyc));
            end
        end
        if (b3.ack0 || b3.ack1) begin
            chk("d3_ack_expected", 32'(ackq3.size() != 0), 32'd1);
            if (ackq3.size() != 0) begin
                ea = ackq3.pop_front();
                chk("d3_ack_port", 32'(b3.ack1), 32'(ea.port));
                chk("d3_ack_rdata", 32'(b3.rdata), 32'(ea.rdata));
                chk("d3_ack_cycle", 32'(cyc), 32'(ea.cyc));
            end
        end
    end

    task automatic drive_port(input bit port, input bit req, input bit we,
                              input logic [7:0] addr, input logic [7:0] wdata);
        if (port) begin
            b1.req1 = req; b1.we1 = we; b1.addr1 = addr; b1.wdata1 = wdata;
        end else begin
            b1.req0 = req; b1.we0 = we; b1.addr0 = addr; b1.wdata0 = wdata;
        end
    endtask

    // One transaction on the MEM_LAT=1 instance: req held until ack, dropped on the ack cycle.
    task automatic txn(input bit port, input bit we, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rdata);
        int  n;
        bit  got;
        stb_exp_t es;
        ack_exp_t ea;
        @(negedge clk);
        drive_port(port, 1'b1, we, addr, wdata);
        n  = cyc;
        es = '{we, addr, wdata, n + 1};
        ea = '{port, exp_rdata, n + 3};
        stbq1.push_back(es);
        ackq1.push_back(ea);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = port ? b1.ack1 : b1.ack0;
        end
        chk("txn_ack_seen", 32'(got), 32'd1);
        drive_port(port, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int cnt;
        bit got;
        logic p;
        stb_exp_t es;
        ack_exp_t ea;

        b1.req0 = 0; b1.we0 = 0; b1.addr0 = 0; b1.wdata0 = 0;
        b1.req1 = 0; b1.we1 = 0; b1.addr1 = 0; b1.wdata1 = 0;
        b3.req0 = 0; b3.we0 = 0; b3.addr0 = 0; b3.wdata0 = 0;
        b3.req1 = 0; b3.we1 = 0; b3.addr1 = 0; b3.wdata1 = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack0", 32'(b1.ack0), 32'd0);
        chk("rst_ack1", 32'(b1.ack1), 32'd0);
        chk("rst_rdata", 32'(b1.rdata), 32'd0);
        chk("rst_busy", 32'(b1.busy), 32'd0);
        chk("rst_gnt_id", 32'(b1.gnt_id), 32'd0);
        chk("rst_mem_re", 32'(b1.mem_re), 32'd0);
        chk("rst_mem_we", 32'(b1.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(b1.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(b1.mem_wdata), 32'd0);
        chk("rst_d3_busy", 32'(b3.busy), 32'd0);
        rst_n = 1'b1;

        // Single read, single write (rdata unchanged)
        txn(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        txn(1'b1, 1'b1, 8'h20, 8'h3C, 8'hA5);

        // Contention: last grant was port 1, so port 0 wins first
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive_port(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
        n = cyc;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            p = 1'b0;
`else
            p = (k % 2 == 1);
`endif
            es = '{1'b0, (p ? 8'h20 : 8'h10), 8'h00, n + 1 + 4 * k};
            ea = '{p, (p ? 8'h3C : 8'hA5), n + 3 + 4 * k};
            stbq1.push_back(es);
            ackq1.push_back(ea);
        end
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 4; i++) begin
            @(negedge clk);
            if (b1.ack0 || b1.ack1) cnt++;
        end
        chk("contention_ack_count", 32'(cnt), 32'd4);
        drive_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

        // Read-back of the write via port 0
        txn(1'b0, 1'b0, 8'h20, 8'h00, 8'h3C);

        // Request withdrawn in the ISSUE cycle
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 8'h30, 8'h00);
        n  = cyc;
        es = '{1'b0, 8'h30, 8'h00, n + 1};
        ea = '{1'b0, 8'h77, n + 3};
        stbq1.push_back(es);
        ackq1.push_back(ea);
        @(negedge clk);
        drive_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (6) @(negedge clk);
        chk("withdraw_all_seen", 32'(stbq1.size() + ackq1.size()), 32'd0);

        // MEM_LAT=3 read
        @(negedge clk);
        b3.req0 = 1'b1; b3.we0 = 1'b0; b3.addr0 = 8'h05;
        n  = cyc;
        es = '{1'b0, 8'h05, 8'h00, n + 1};
        ea = '{1'b0, (8'(n + 4) ^ 8'h5A), n + 5};
        stbq3.push_back(es);
        ackq3.push_back(ea);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = b3.ack0;
        end
        chk("lat3_ack_seen", 32'(got), 32'd1);
        b3.req0 = 1'b0;

        // Reset during WAIT: strobe expected, no ack
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        n  = cyc;
        es = '{1'b0, 8'h10, 8'h00, n + 1};
        stbq1.push_back(es);
        @(negedge clk);
        @(negedge clk);
        chk("busy_in_wait", 32'(b1.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        drive_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("abort_busy", 32'(b1.busy), 32'd0);
        chk("abort_mem_re", 32'(b1.mem_re), 32'd0);
        chk("abort_mem_we", 32'(b1.mem_we), 32'd0);
        chk("abort_ack0", 32'(b1.ack0), 32'd0);
        chk("abort_ack1", 32'(b1.ack1), 32'd0);
        chk("abort_rdata", 32'(b1.rdata), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // After release, port 1 alone is granted
        txn(1'b1, 1'b0, 8'h20, 8'h00, 8'h3C);

        repeat (4) @(negedge clk);
        chk("d1_queues_empty", 32'(stbq1.size() + ackq1.size()), 32'd0);
        chk("d3_queues_empty", 32'(stbq3.size() + ackq3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory_unit port between two requesters: port 0 is the CPU core; port 1 is the auxiliary master (UART loader/debug).
- Sits inside chipset between the requesters and memory_unit.
- Latches the winning request, drives one memory strobe, waits the memory read latency, then returns data and a one-cycle ack to the winner.
- Arbitration is round-robin by default.

Parameters:
- DATA_W, 8, width of the data buses (matches `REGSIZE).
- ADDR_W, 8, width of the address bus.
- MEM_LAT, 1, cycles from the strobe cycle until mem_rdata is valid; legal range 1..15.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- req0  input  1  port 0 request.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  port 0 completion pulse.
- req1, we1, addr1, wdata1  input  1/1/ADDR_W/DATA_W  port 1, same meaning as port 0.
- ack1  output  1  port 1 completion pulse.
- rdata  output  DATA_W  read data, valid while ack0 or ack1 is high.
- busy  output  1  high in any state other than IDLE.
- gnt_id  output  1  index of the current or last granted port.
- mem_re  output  1  memory read strobe.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.

Behaviour:
- Reset (async, RESET_N=0): state=IDLE. All outputs 0, including mem strobes, ack0/1, rdata, busy and gnt_id. The last-grant pointer is set to 1, so port 0 wins the first contention.
- Reset mid-transaction: abort immediately. Strobes drop asynchronously. No ack is issued for the aborted transaction.
- All registered outputs change on the CLOCK rising edge only.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high: select the winner, latch its we/addr/wdata, set gnt_id, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_re = ~we_latched, mem_we = we_latched.
  - mem_addr/mem_wdata = latched values.
  - Load a wait counter with MEM_LAT. Go to WAIT.
- WAIT:
  - Strobes are 0. mem_addr/mem_wdata hold their values.
  - The counter decrements each cycle.
  - On the cycle the counter reaches 1: if the transaction is a read, register mem_rdata into rdata. Go to RESP.
  - WAIT lasts exactly MEM_LAT cycles.
- RESP (1 cycle):
  - ack of the granted port = 1.
  - rdata holds the captured value; on a write, rdata keeps its previous value.
  - Update the last-grant pointer to gnt_id. Go to IDLE.
- Latency: req seen in IDLE at cycle N gives the strobe at N+1 and the ack at N+2+MEM_LAT. Back-to-back transactions repeat every 3+MEM_LAT cycles.
- Round-robin arbitration:
  - Only one req high: that port wins.
  - Both high: the port not equal to the last-grant pointer wins.
- Request fields are sampled only on the grant cycle. Changes after the grant are ignored.
- req dropped after grant: the transaction still completes and ack still pulses.
- A requester holds req until it sees ack. It must drop or renew req on the ack cycle. A req still high in the cycle after ack is treated as a new request.
- ack0 and ack1 are never high together. Exactly one ack pulse per granted transaction.
- mem_re and mem_we are never high together, and never high outside ISSUE.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins contention, and the last-grant pointer is unused.
- Undefined: round-robin as described under Behaviour.
- All other timing is identical in both modes.

Test Plan:
- Single read, MEM_LAT=1:
  - Stimulus: req0=1, we0=0, addr0=8'h10; memory returns 8'hA5.
  - Response: mem_re high one cycle at N+1 with mem_addr=8'h10; ack0 at N+3 with rdata=8'hA5; ack1 stays 0.
- Single write:
  - Stimulus: req1=1, we1=1, addr1=8'h20, wdata1=8'h3C.
  - Response: mem_we one cycle with mem_addr=8'h20, mem_wdata=8'h3C; ack1 at N+3; rdata unchanged; a read-back via port 0 returns 8'h3C.
- Contention:
  - Stimulus: req0 and req1 held high continuously for 4 transactions.
  - Response, round-robin: grant order 0,1,0,1, acks 4 cycles apart.
  - Response, ARB_FIXED_PRIO_EN defined: grant order 0,0,0,0.
- Latency parameter:
  - Stimulus: MEM_LAT=3, read of addr 8'h05.
  - Response: ack at N+5; rdata equals the mem_rdata value present 3 cycles after the strobe.
- Request withdrawal:
  - Stimulus: req0 drops in the ISSUE cycle.
  - Response: ack0 still pulses at N+3; no second strobe follows.
- Reset mid-transaction:
  - Stimulus: RESET_N=0 asserted during WAIT, between clock edges.
  - Response: busy, strobes, ack0/1 and rdata go to 0 immediately, with no ack afterwards. After release, req1 alone is granted in 4 cycles.
